// File: rtl/avalon_pixel_mem_slave_pkg.sv
// Shared types and constants for the pixel store Avalon-MM slave.
package pixel_mem_pkg;

    typedef enum logic [1:0] {CLEAR, READY, DRAIN} state_e;

    localparam logic [31:0] BAD_READ_DATA   = 32'hDEADBEEF;
    localparam int          BYTEENABLEWIDTH = 4;

endpackage

// File: rtl/avalon_pixel_mem_slave_if.sv
// Avalon-MM bus bundle between the image core master and the pixel store.
interface avalon_pixel_mem_slave_if #(
    parameter int ADDRESSWIDTH = 26,
    parameter int DATAWIDTH    = 32
);
    logic [ADDRESSWIDTH-1:0] slave_address;
    logic [DATAWIDTH-1:0]    slave_writedata;
    logic                    slave_write;
    logic                    slave_read;
    logic                    slave_waitrequest;
    logic [DATAWIDTH-1:0]    slave_readdata;
    logic                    slave_readdatavalid;

    modport master (
        output slave_address, slave_writedata, slave_write, slave_read,
        input  slave_waitrequest, slave_readdata, slave_readdatavalid
    );

    modport slave (
        input  slave_address, slave_writedata, slave_write, slave_read,
        output slave_waitrequest, slave_readdata, slave_readdatavalid
    );
endinterface

// File: rtl/avalon_pixel_mem_slave_rd_pipe.sv
// Fixed-latency read return pipe: carries {valid, data, bad} from acceptance
// to the return port; its valid output also retires the pending count.
module avalon_rd_pipe
    import pixel_mem_pkg::*;
#(
    parameter int DATAWIDTH    = 32,
    parameter int READ_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 push_bad,
    input  logic [DATAWIDTH-1:0] push_data,
    output logic                 rd_valid,
    output logic [DATAWIDTH-1:0] rd_data
);
    logic [READ_LATENCY-1:0]                vld_pipe;
    logic [READ_LATENCY-1:0]                bad_pipe;
    logic [READ_LATENCY-1:0][DATAWIDTH-1:0] dat_pipe;

    // Payload only advances with a valid beat, so the last stage holds the
    // previous return while readdatavalid is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            bad_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[0] <= push;
            if (push) begin
                bad_pipe[0] <= push_bad;
                dat_pipe[0] <= push_data;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                if (vld_pipe[i-1]) begin
                    bad_pipe[i] <= bad_pipe[i-1];
                    dat_pipe[i] <= dat_pipe[i-1];
                end
            end
        end
    end

    assign rd_valid = vld_pipe[READ_LATENCY-1];
    assign rd_data  = bad_pipe[READ_LATENCY-1] ? DATAWIDTH'(BAD_READ_DATA)
                                               : dat_pipe[READ_LATENCY-1];
endmodule

// File: rtl/avalon_pixel_mem_slave.sv
// Avalon-MM pixel store: fixed-latency pipelined reads, single-cycle writes,
// zero-fill FSM after reset or on clear_req, sticky error flag.
module avalon_pixel_mem_slave
    import pixel_mem_pkg::*;
#(
    parameter int                      ADDRESSWIDTH = 26,
    parameter int                      DATAWIDTH    = 32,
    parameter logic [ADDRESSWIDTH-1:0] BASE_ADDR    = '0,
    parameter int                      DEPTH        = 1024,
    parameter int                      READ_LATENCY = 2,
    parameter int                      MAX_PENDING  = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    avalon_pixel_mem_slave_if.slave        bus,
    input  logic                           clear_req,
    output logic                           busy,
    output logic                           err_flag,
    input  logic                           err_clear
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(MAX_PENDING + 1);
    localparam logic [ADDRESSWIDTH:0] SPAN = (ADDRESSWIDTH+1)'(4 * DEPTH);

    state_e                  state, state_nxt;
    logic [AW-1:0]           clr_cnt;
    logic [PW-1:0]           pending;
    logic [DATAWIDTH-1:0]    mem [DEPTH];

    logic [ADDRESSWIDTH-1:0] offset;
    logic [AW-1:0]           idx;
    logic                    in_range, acc, acc_wr, acc_rd, err_set, ret;

    // Stall depends on registered state only; no input-to-waitrequest path.
    assign bus.slave_waitrequest = (state != READY) || (pending == PW'(MAX_PENDING));
    assign busy = (state != READY);

    assign offset   = bus.slave_address - BASE_ADDR;
    assign idx      = offset[AW+1:2];
    assign in_range = (bus.slave_address[1:0] == 2'b00) &&
                      (bus.slave_address >= BASE_ADDR) &&
                      ({1'b0, offset} < SPAN);

    assign acc     = (bus.slave_read || bus.slave_write) && !bus.slave_waitrequest;
    assign acc_wr  = acc && bus.slave_write;
    assign acc_rd  = acc && bus.slave_read && !bus.slave_write;
    assign err_set = acc && (!in_range || (bus.slave_read && bus.slave_write));

    always_ff @(posedge clk) begin
        if (state == CLEAR)
            mem[clr_cnt] <= '0;
        else if (acc_wr && in_range)
            mem[idx] <= bus.slave_writedata;
    end

    // Read data is sampled before the edge, i.e. memory as of acceptance.
    avalon_rd_pipe #(
        .DATAWIDTH    (DATAWIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_rd_pipe (
        .clk       (clk),
        .reset     (reset),
        .push      (acc_rd),
        .push_bad  (!in_range),
        .push_data (mem[idx]),
        .rd_valid  (ret),
        .rd_data   (bus.slave_readdata)
    );

    assign bus.slave_readdatavalid = ret;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= (state == CLEAR) ? clr_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (clr_cnt == AW'(DEPTH - 1)) state_nxt = READY;
            READY:   if (clear_req)                 state_nxt = DRAIN;
            DRAIN:   if (pending == '0)             state_nxt = CLEAR;
            default:                                state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pending <= '0;
        else if (acc_rd && !ret && pending != PW'(MAX_PENDING))
            pending <= pending + 1'b1;
        else if (ret && !acc_rd && pending != '0)
            pending <= pending - 1'b1;
    end

    // A new error in the same cycle as err_clear keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_flag <= 1'b0;
        else if (err_set)
            err_flag <= 1'b1;
        else if (err_clear)
            err_flag <= 1'b0;
    end
endmodule

// File: doc/avalon_pixel_mem_slave.md
Name: avalon_pixel_mem_slave

Overview:
- Avalon-MM slave responder modelling the SDRAM pixel store on the far side of the image core's bus master.
- Serves pipelined reads with a fixed latency, honours waitrequest and readdatavalid, and accepts single-cycle writes.
- Used as the memory-side target in simulation and as an on-chip pixel buffer on the DE2i-150.
- Contains a clear FSM that zero-fills memory after reset or on request.

Parameters:
ADDRESSWIDTH, 26, byte-address width of slave_address
DATAWIDTH, 32, data width
BASE_ADDR, 26'h0000000, byte address of word 0
DEPTH, 1024, words of storage (power of two)
READ_LATENCY, 2, cycles from read acceptance to readdatavalid (>=1)
MAX_PENDING, 4, maximum outstanding accepted reads (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
slave_address  in  ADDRESSWIDTH  byte address, word aligned
slave_writedata  in  DATAWIDTH  write data
slave_write  in  1  write request
slave_read  in  1  read request
slave_waitrequest  out  1  stall; a request is accepted only when low
slave_readdata  out  DATAWIDTH  read return data
slave_readdatavalid  out  1  readdata valid strobe
clear_req  in  1  pulse: zero-fill memory
busy  out  1  clear in progress
err_flag  out  1  sticky protocol/range error
err_clear  in  1  clears err_flag

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high.
- Reset values: slave_readdata=0, slave_readdatavalid=0, err_flag=0, busy=1, slave_waitrequest=1.
- Reset mid-operation: all pending reads are discarded with no readdatavalid, and the FSM enters CLEAR.
- FSM states:
  - CLEAR: the clear counter runs 0..DEPTH-1 and writes 0 to one word per cycle. busy=1 and waitrequest=1. After the word at DEPTH-1 is written, go to READY.
  - READY: normal service. If clear_req=1, go to DRAIN.
  - DRAIN: waitrequest=1. Stay until the pending count is 0, then go to CLEAR with the counter at 0.
  - clear_req is ignored outside READY.
- Acceptance: a request is accepted when (read or write) && !waitrequest.
- waitrequest = (state!=READY) || (pending==MAX_PENDING). It is a function of registered state only, with no combinational path from inputs.
- Address decode:
  - In range when address[1:0]==0 and BASE_ADDR <= address < BASE_ADDR + 4*DEPTH.
  - Word index = (address - BASE_ADDR) >> 2, truncated to clog2(DEPTH) bits.
- Accepted in-range write: stored at the clock edge of acceptance.
- Accepted out-of-range write: dropped, err_flag set.
- Accepted read:
  - Enters the latency pipe. slave_readdatavalid pulses exactly READ_LATENCY cycles later.
  - Returns memory contents as of the acceptance edge (the write is visible to a read accepted the next cycle or later).
  - Returns in acceptance order.
  - Out-of-range read returns 32'hDEADBEEF with readdatavalid, and sets err_flag.
  - slave_readdata holds its last value when readdatavalid is low.
- Simultaneous read and write in one accepted cycle: the write is performed, the read is ignored (no return), err_flag set.
- Pending counter: +1 on read accept, -1 on return. Both in one cycle leave it unchanged. Saturates at 0..MAX_PENDING. Back-to-back accepted reads sustain one return per cycle.
- err_flag: sticky. err_clear clears it, but a new error in the same cycle wins (flag stays 1).

Decomposition:
- Package pixel_mem_pkg holds:
  - state enum {CLEAR, READY, DRAIN};
  - BAD_READ_DATA=32'hDEADBEEF;
  - BYTEENABLEWIDTH=4.
- One sub-module, avalon_rd_pipe:
  - READ_LATENCY-deep shift register of {valid, data, bad};
  - carries accepted reads to the return port;
  - also reports returns to the pending counter.

Test Plan:
- Reset release -> busy=1 and waitrequest=1 for exactly DEPTH cycles, then both 0; a read of word 5 returns 0.
- Write 32'h12345678 to BASE+0x10, read next cycle -> readdatavalid exactly 2 cycles after acceptance, data 32'h12345678.
- Continuous reads of BASE+0..BASE+0x1C with READ_LATENCY=8, MAX_PENDING=4 -> waitrequest rises after the 4th acceptance; returns are in order; no read is lost; pending never exceeds 4.
- Read at BASE+4*DEPTH, then write at BASE+0x2 -> read returns DEADBEEF, write is dropped, err_flag=1; err_clear -> 0.
- Read and write asserted together at BASE+0x8 with data 0xA5 -> no readdatavalid, word 2 = 0xA5, err_flag=1.
- Assert reset with 3 reads pending -> no readdatavalid afterwards, pending=0, CLEAR restarts. Separately, clear_req with 2 pending -> both return, then DEPTH-cycle clear.
